tweakey_sched_ctrl: RTL and testbench

//  Sequencer for the Skinny-128-384+ tweakey datapath used in the Romulus-N core.

---
 rtl/tk_sched_pkg.sv | 20 ++
 rtl/rc_lfsr6.sv | 36 +++
 rtl/tweakey_sched_ctrl.sv | 114 +++++++++++
 tb/tb_tweakey_sched_ctrl.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tk_sched_pkg.sv
// rtl/tk_sched_pkg.sv - shared types, constants and round-constant LFSR step for the tweakey sequencer
package tk_sched_pkg;

  localparam int NR_DEFAULT = 40;
  localparam int RC_WIDTH = 6;
  localparam logic [RC_WIDTH-1:0] RC_INIT = 6'h01;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } tk_state_e;

  // Skinny 6-bit round-constant LFSR: shift left, feedback rc5 ^ rc4 ^ 1
  function automatic logic [RC_WIDTH-1:0] rc_next(input logic [RC_WIDTH-1:0] rc);
    return {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
  endfunction

endpackage

// File: rtl/rc_lfsr6.sv
// rtl/rc_lfsr6.sv - 6-bit round-constant register with load/step/hold controls
module rc_lfsr6
  import tk_sched_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_i,
  input  logic                step_i,
  output logic [RC_WIDTH-1:0] rc_o
);

  logic [RC_WIDTH-1:0] rc_q;
  logic [RC_WIDTH-1:0] rc_d;

  // Load has priority over step; neither asserted holds the current constant
  always_comb begin
    rc_d = rc_q;
    if (load_i) begin
      rc_d = RC_INIT;
    end else if (step_i) begin
      rc_d = rc_next(rc_q);
    end
  end

  // Constant register, cleared to zero on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rc_q <= '0;
    end else begin
      rc_q <= rc_d;
    end
  end

  assign rc_o = rc_q;

endmodule

// File: rtl/tweakey_sched_ctrl.sv
// rtl/tweakey_sched_ctrl.sv - Skinny-128-384+ tweakey schedule sequencer; optional stall via TKCTRL_HOLD_EN
module tweakey_sched_ctrl
  import tk_sched_pkg::*;
#(
  parameter int NR  = NR_DEFAULT,
  parameter int RCW = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
`ifdef TKCTRL_HOLD_EN
  input  logic                  hold_i,
`endif
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  tk_sel_o,
  output logic                  tk_en_o,
  output logic                  core_en_o,
  output logic [$clog2(NR)-1:0] round_o,
  output logic [RCW-1:0]        rc_o
);

  localparam int RW = $clog2(NR);
  localparam logic [RW-1:0] LAST_ROUND = RW'(NR - 1);

  tk_state_e           state_q;
  tk_state_e           state_d;
  logic [RW-1:0]       round_q;
  logic [RW-1:0]       round_d;
  logic                rc_load;
  logic                rc_step;
  logic                stall;
  logic [RC_WIDTH-1:0] rc_w;

`ifdef TKCTRL_HOLD_EN
  assign stall = hold_i;
`else
  assign stall = 1'b0;
`endif

  rc_lfsr6 u_rc (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (rc_load),
    .step_i (rc_step),
    .rc_o   (rc_w)
  );

  // Next-state, round counter update and Moore output decode; a stall only matters in LOAD/ROUND
  always_comb begin
    state_d   = state_q;
    round_d   = round_q;
    rc_load   = 1'b0;
    rc_step   = 1'b0;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    tk_sel_o  = 1'b0;
    tk_en_o   = 1'b0;
    core_en_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        busy_o   = 1'b1;
        tk_sel_o = 1'b1;
        tk_en_o  = !stall;
        if (!stall) begin
          state_d = ROUND;
          round_d = '0;
          rc_load = 1'b1;
        end
      end
      ROUND: begin
        busy_o    = 1'b1;
        core_en_o = !stall;
        // last key is already in the schedule regs; do not advance past it
        tk_en_o   = !stall && (round_q != LAST_ROUND);
        if (!stall) begin
          if (round_q == LAST_ROUND) begin
            state_d = DONE;
          end else begin
            round_d = round_q + 1'b1;
            rc_step = 1'b1;
          end
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // round/rc are only meaningful once a call has started; IDLE presents zeros
    round_o = (state_q == IDLE) ? '0 : round_q;
    rc_o    = (state_q == IDLE) ? '0 : RCW'(rc_w);
  end

  // State and round counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
    end
  end

endmodule

// File: tb/tb_tweakey_sched_ctrl.sv
// tb/tb_tweakey_sched_ctrl.sv - self-checking bench for tweakey_sched_ctrl (NR=40 and NR=4 instances)
module tb_tweakey_sched_ctrl;

  localparam int NR = 40;
`ifdef TKCTRL_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif
  localparam logic [16:0] M_ALL = 17'h1FFFF;
  localparam logic [16:0] M_CTL = 17'h1F000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_i = 1'b0;
  logic hold_i = 1'b0;
  logic start4 = 1'b0;

  logic busy_o, done_o, tk_sel_o, tk_en_o, core_en_o;
  logic [5:0] round_o;
  logic [5:0] rc_o;
  logic busy4, done4, sel4, en4, core4;
  logic [1:0] round4;
  logic [5:0] rc4;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [16:0] v;
    logic [16:0] m;
    bit          holdable;
  } exp_t;
  exp_t q[$];

  logic [5:0] rc_tab [10];
  logic [5:0] rc4_tab [4];

  always #5 clk = ~clk;

  tweakey_sched_ctrl #(.NR(NR), .RCW(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start_i),
`ifdef TKCTRL_HOLD_EN
    .hold_i    (hold_i),
`endif
    .busy_o    (busy_o),
    .done_o    (done_o),
    .tk_sel_o  (tk_sel_o),
    .tk_en_o   (tk_en_o),
    .core_en_o (core_en_o),
    .round_o   (round_o),
    .rc_o      (rc_o)
  );

  tweakey_sched_ctrl #(.NR(4), .RCW(6)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start4),
`ifdef TKCTRL_HOLD_EN
    .hold_i    (1'b0),
`endif
    .busy_o    (busy4),
    .done_o    (done4),
    .tk_sel_o  (sel4),
    .tk_en_o   (en4),
    .core_en_o (core4),
    .round_o   (round4),
    .rc_o      (rc4)
  );

  // round constant of round n, from the recurrence starting at 01
  function automatic logic [5:0] spec_rc(input int n);
    logic [5:0] r;
    r = 6'h01;
    for (int i = 0; i < n; i++) r = {r[4:0], ~(r[5] ^ r[4])};
    return r;
  endfunction

  function automatic bit hold_eff();
    return HOLD_EN & hold_i;
  endfunction

  // whole call as a list of expected cycles: LOAD, NR rounds, DONE
  task automatic push_call(input int nr);
    exp_t e;
    e.v = {5'b10110, 12'h000};
    e.m = M_CTL;
    e.holdable = 1'b1;
    q.push_back(e);
    for (int r = 0; r < nr; r++) begin
      e.v = {1'b1, 1'b0, 1'b0, (r < nr - 1), 1'b1, 6'(r), spec_rc(r)};
      e.m = M_ALL;
      e.holdable = 1'b1;
      q.push_back(e);
    end
    e.v = {5'b01000, 6'(nr - 1), spec_rc(nr - 1)};
    e.m = M_ALL;
    e.holdable = 1'b0;
    q.push_back(e);
  endtask

  function automatic logic [16:0] exp_vec();
    logic [16:0] v;
    if (q.size() == 0) return 17'h0;
    v = q[0].v;
    if (hold_eff() && q[0].holdable) v[13:12] = 2'b00;
    return v;
  endfunction

  function automatic logic [16:0] exp_mask();
    return (q.size() == 0) ? M_ALL : q[0].m;
  endfunction

  function automatic logic [16:0] act_vec();
    return {busy_o, done_o, tk_sel_o, tk_en_o, core_en_o, round_o, rc_o};
  endfunction

  // advance the reference over one clock edge, then move to the next falling edge
  task automatic tick();
    if (q.size() == 0) begin
      if (start_i) push_call(NR);
    end else if (!(hold_eff() && q[0].holdable)) begin
      void'(q.pop_front());
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start_i = 1'b0;
    hold_i = 1'b0;
    q.delete();
    @(negedge clk);
    #1;
    tests_run++;
    if (act_vec() !== 17'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h want %h", act_vec(), 17'h0);
    end
    start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    tests_run++;
    if (act_vec() !== 17'h0 || busy4 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ignores_start: got %h want %h", act_vec(), 17'h0);
    end
    start_i = 1'b0;
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (act_vec() !== 17'h0) begin
      tests_failed++;
      $display("FAIL reset_release: got %h want %h", act_vec(), 17'h0);
    end
  endtask

  task automatic test_single_call();
    int done_cnt = 0, done_cyc = -1, busy_cnt = 0, busy_first = -1, busy_last = -1;
    for (int c = 0; c < 46; c++) begin
      start_i = (c == 0);
      #1;
      tests_run++;
      if ((act_vec() & exp_mask()) !== (exp_vec() & exp_mask())) begin
        tests_failed++;
        $display("FAIL single_trace cycle %0d: got %h want %h", c, act_vec() & exp_mask(), exp_vec() & exp_mask());
      end
      if (c >= 2 && c <= 11) begin
        tests_run++;
        if (rc_o !== rc_tab[c-2]) begin
          tests_failed++;
          $display("FAIL single_rc round %0d: got %h want %h", c - 2, rc_o, rc_tab[c-2]);
        end
      end
      if (done_o) begin done_cnt++; done_cyc = c; end
      if (busy_o) begin
        busy_cnt++;
        if (busy_first < 0) busy_first = c;
        busy_last = c;
      end
      tick();
    end
    tests_run++;
    if (done_cnt !== 1 || done_cyc !== 42) begin
      tests_failed++;
      $display("FAIL single_done: got count %0d at cycle %0d want 1 at 42", done_cnt, done_cyc);
    end
    tests_run++;
    if (busy_cnt !== 41 || busy_first !== 1 || busy_last !== 41) begin
      tests_failed++;
      $display("FAIL single_busy: got %0d cycles %0d..%0d want 41 cycles 1..41", busy_cnt, busy_first, busy_last);
    end
  endtask

  task automatic test_back_to_back();
    int loads[$];
    int guard = 0;
    for (int c = 0; c < 132; c++) begin
      start_i = 1'b1;
      #1;
      tests_run++;
      if ((act_vec() & exp_mask()) !== (exp_vec() & exp_mask())) begin
        tests_failed++;
        $display("FAIL b2b_trace cycle %0d: got %h want %h", c, act_vec() & exp_mask(), exp_vec() & exp_mask());
      end
      if (tk_sel_o) loads.push_back(c);
      tick();
    end
    start_i = 1'b0;
    while (q.size() != 0 && guard < 60) begin
      #1;
      tests_run++;
      if ((act_vec() & exp_mask()) !== (exp_vec() & exp_mask())) begin
        tests_failed++;
        $display("FAIL b2b_drain: got %h want %h", act_vec() & exp_mask(), exp_vec() & exp_mask());
      end
      tick();
      guard++;
    end
    tests_run++;
    if (loads.size() !== 4) begin
      tests_failed++;
      $display("FAIL b2b_load_count: got %0d want 4", loads.size());
    end else begin
      for (int i = 1; i < 4; i++) begin
        tests_run++;
        if (loads[i] - loads[i-1] !== 43) begin
          tests_failed++;
          $display("FAIL b2b_period: got %0d want 43", loads[i] - loads[i-1]);
        end
      end
    end
  endtask

  task automatic test_start_during_round();
    int done_cnt = 0, done_cyc = -1;
    for (int c = 0; c < 50; c++) begin
      start_i = (c == 0) || (c == 42) || (c >= 3 && c <= 40 && $urandom_range(0, 1) == 1);
      #1;
      tests_run++;
      if ((act_vec() & exp_mask()) !== (exp_vec() & exp_mask())) begin
        tests_failed++;
        $display("FAIL noqueue_trace cycle %0d: got %h want %h", c, act_vec() & exp_mask(), exp_vec() & exp_mask());
      end
      if (done_o) begin done_cnt++; done_cyc = c; end
      tick();
    end
    tests_run++;
    if (done_cnt !== 1 || done_cyc !== 42) begin
      tests_failed++;
      $display("FAIL noqueue_done: got count %0d at cycle %0d want 1 at 42", done_cnt, done_cyc);
    end
  endtask

  task automatic test_reset_mid_call();
    for (int c = 0; c < 19; c++) begin
      start_i = (c == 0);
      #1;
      tests_run++;
      if ((act_vec() & exp_mask()) !== (exp_vec() & exp_mask())) begin
        tests_failed++;
        $display("FAIL midrst_trace cycle %0d: got %h want %h", c, act_vec() & exp_mask(), exp_vec() & exp_mask());
      end
      tick();
    end
    #1;
    tests_run++;
    if (round_o !== 6'd17 || busy_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_round17: got round %0d busy %b want 17 1", round_o, busy_o);
    end
    rst_n = 1'b0;
    q.delete();
    #1;
    tests_run++;
    if (act_vec() !== 17'h0) begin
      tests_failed++;
      $display("FAIL midrst_immediate: got %h want %h", act_vec(), 17'h0);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      tests_run++;
      if (act_vec() !== 17'h0) begin
        tests_failed++;
        $display("FAIL midrst_held: got %h want %h", act_vec(), 17'h0);
      end
    end
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      start_i = (c == 0);
      #1;
      tests_run++;
      if ((act_vec() & exp_mask()) !== (exp_vec() & exp_mask())) begin
        tests_failed++;
        $display("FAIL midrst_restart cycle %0d: got %h want %h", c, act_vec() & exp_mask(), exp_vec() & exp_mask());
      end
      if (c == 2) begin
        tests_run++;
        if (rc_o !== 6'h01 || round_o !== 6'd0) begin
          tests_failed++;
          $display("FAIL midrst_round0: got rc %h round %0d want 01 0", rc_o, round_o);
        end
      end
      tick();
    end
    start_i = 1'b0;
    for (int c = 0; c < 40 && q.size() != 0; c++) tick();
  endtask

`ifdef TKCTRL_HOLD_EN
  task automatic test_hold();
    int done_cyc = -1;
    for (int c = 0; c < 50; c++) begin
      start_i = (c == 0);
      hold_i = (c >= 7 && c <= 9);
      #1;
      tests_run++;
      if ((act_vec() & exp_mask()) !== (exp_vec() & exp_mask())) begin
        tests_failed++;
        $display("FAIL hold_trace cycle %0d: got %h want %h", c, act_vec() & exp_mask(), exp_vec() & exp_mask());
      end
      if (c >= 7 && c <= 9) begin
        tests_run++;
        if (round_o !== 6'd5 || rc_o !== 6'h3E || tk_en_o !== 1'b0 || core_en_o !== 1'b0 || busy_o !== 1'b1) begin
          tests_failed++;
          $display("FAIL hold_frozen cycle %0d: got round %0d rc %h en %b core %b want 5 3e 0 0", c, round_o, rc_o, tk_en_o, core_en_o);
        end
      end
      if (done_o) done_cyc = c;
      tick();
    end
    hold_i = 1'b0;
    tests_run++;
    if (done_cyc !== 45) begin
      tests_failed++;
      $display("FAIL hold_done: got cycle %0d want 45", done_cyc);
    end
  endtask
`endif

  task automatic test_random();
    int guard = 0;
    for (int c = 0; c < 800; c++) begin
      start_i = ($urandom_range(0, 3) == 0);
      hold_i = HOLD_EN && ($urandom_range(0, 5) == 0);
      #1;
      tests_run++;
      if ((act_vec() & exp_mask()) !== (exp_vec() & exp_mask())) begin
        tests_failed++;
        $display("FAIL random_trace cycle %0d: got %h want %h", c, act_vec() & exp_mask(), exp_vec() & exp_mask());
      end
      tick();
    end
    start_i = 1'b0;
    hold_i = 1'b0;
    while (q.size() != 0 && guard < 60) begin
      tick();
      guard++;
    end
    #1;
    tests_run++;
    if (q.size() != 0 || act_vec() !== 17'h0) begin
      tests_failed++;
      $display("FAIL random_drain: got %h want %h (timeout)", act_vec(), 17'h0);
    end
  endtask

  task automatic test_nr4();
    logic [12:0] e, m, a;
    int done_cyc = -1;
    for (int c = 0; c < 9; c++) begin
      start4 = (c == 0);
      #1;
      e = 13'h0;
      m = 13'h1FFF;
      if (c == 1) begin
        e = {5'b10110, 8'h00};
        m = 13'h1F00;
      end else if (c >= 2 && c <= 5) begin
        e = {1'b1, 1'b0, 1'b0, (c < 5), 1'b1, 2'(c - 2), rc4_tab[c-2]};
      end else if (c == 6) begin
        e = {5'b01000, 2'd3, 6'h0F};
      end
      a = {busy4, done4, sel4, en4, core4, round4, rc4};
      tests_run++;
      if ((a & m) !== (e & m)) begin
        tests_failed++;
        $display("FAIL nr4_trace cycle %0d: got %h want %h", c, a & m, e & m);
      end
      if (done4) done_cyc = c;
      tick();
    end
    tests_run++;
    if (done_cyc !== 6) begin
      tests_failed++;
      $display("FAIL nr4_done: got cycle %0d want 6", done_cyc);
    end
  endtask

  initial begin
    rc_tab = '{6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F};
    rc4_tab = '{6'h01, 6'h03, 6'h07, 6'h0F};
    test_reset();
    test_single_call();
    test_back_to_back();
    test_start_during_round();
    test_reset_mid_call();
`ifdef TKCTRL_HOLD_EN
    test_hold();
`endif
    test_nr4();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
